sad_loader: RTL and testbench

SAD_LOADER -- requirements
Module: sad_loader

---
 rtl/sad_pkg.sv | 21 ++
 rtl/sad_loader_if.sv | 39 +++
 rtl/sad_byte_packer.sv | 49 ++++
 rtl/sad_loader.sv | 145 ++++++++++++++
 tb/tb_sad_loader.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sad_pkg.sv
// Shared widths, block size and loader state encoding for the SAD loader slice.
// Pure declarations: no latency, no flow control.
package sad_pkg;

    localparam int A_WIDTH         = 8;
    localparam int D_WIDTH         = 8;
    localparam int WORD_ADDR_W     = 6;
    localparam int WORD_W          = 32;
    localparam int BYTES_PER_BLOCK = 256;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        FLUSH,
        GO,
        WAIT,
        RESULT
    } state_t;

endpackage

// File: rtl/sad_loader_if.sv
// Byte stream, dual memory write ports and SAD core handshake bundled for sad_loader.
// slave = loader side, master = stream source / memories / core side.
interface sad_loader_if;
    import sad_pkg::*;

    logic                   Start;
    logic [D_WIDTH-1:0]     In_Data;
    logic                   In_Valid;
    logic                   In_Ready;

    logic [WORD_W-1:0]      MA_di31;
    logic [WORD_W-1:0]      MB_di31;
    logic [WORD_ADDR_W-1:0] MA_Addr6;
    logic [WORD_ADDR_W-1:0] MB_Addr6;
    logic                   MA_enb;
    logic                   MA_web;
    logic                   MB_enb;
    logic                   MB_web;

    logic                   Go_t;
    logic                   Done_t;
    logic [WORD_W-1:0]      SAD_Out_t;
    logic [WORD_W-1:0]      Sad_Result;
    logic                   Res_Valid;
    logic                   Busy;

    modport slave (
        input  Start, In_Data, In_Valid, Done_t, SAD_Out_t,
        output In_Ready, MA_di31, MB_di31, MA_Addr6, MB_Addr6,
               MA_enb, MA_web, MB_enb, MB_web, Go_t, Sad_Result, Res_Valid, Busy
    );

    modport master (
        output Start, In_Data, In_Valid, Done_t, SAD_Out_t,
        input  In_Ready, MA_di31, MB_di31, MA_Addr6, MB_Addr6,
               MA_enb, MA_web, MB_enb, MB_web, Go_t, Sad_Result, Res_Valid, Busy
    );

endinterface

// File: rtl/sad_byte_packer.sv
// Packs bytes little-endian into 32-bit words; word_dat/word_done are combinational on the 4th byte.
// No backpressure of its own: every byte_vld cycle is consumed.
module sad_byte_packer
    import sad_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               byte_vld,
    input  logic [D_WIDTH-1:0] byte_dat,
    output logic [WORD_W-1:0]  word_dat,
    output logic               word_done
);

    logic [1:0]  lane_q,  lane_d;
    logic [23:0] lanes_q, lanes_d;

    always_comb begin
        lane_d  = lane_q;
        lanes_d = lanes_q;
        if (clr) begin
            lane_d  = '0;
            lanes_d = '0;
        end else if (byte_vld) begin
            lane_d = lane_q + 2'd1;
            case (lane_q)
                2'd0:    lanes_d[7:0]   = byte_dat;
                2'd1:    lanes_d[15:8]  = byte_dat;
                2'd2:    lanes_d[23:16] = byte_dat;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q  <= '0;
            lanes_q <= '0;
        end else begin
            lane_q  <= lane_d;
            lanes_q <= lanes_d;
        end
    end

    // Lane 3 bypasses the register so the word is ready on the accepting edge.
    assign word_done = byte_vld && !clr && (lane_q == 2'd3);
    assign word_dat  = {byte_dat, lanes_q};

endmodule

// File: rtl/sad_loader.sv
// Streams two blocks of bytes into SAD memories A and B, pulses the core, captures its result.
// Word writes land one cycle after the 4th byte; In_Ready is high only in LOAD_A/LOAD_B.
module sad_loader
    import sad_pkg::*;
#(
    parameter int BYTES_PER_BLOCK = sad_pkg::BYTES_PER_BLOCK
)
(
    input  logic         clk,
    input  logic         rst,
    sad_loader_if.slave  bus
);

    localparam logic [A_WIDTH-1:0] LAST_BYTE = A_WIDTH'(BYTES_PER_BLOCK - 1);

    state_t                 state_q,   state_d;
    logic [A_WIDTH-1:0]     cnt_q,     cnt_d;
    logic                   ma_en_q,   ma_en_d;
    logic                   mb_en_q,   mb_en_d;
    logic [WORD_ADDR_W-1:0] ma_addr_q, ma_addr_d;
    logic [WORD_ADDR_W-1:0] mb_addr_q, mb_addr_d;
    logic [WORD_W-1:0]      ma_di_q,   ma_di_d;
    logic [WORD_W-1:0]      mb_di_q,   mb_di_d;
    logic [WORD_W-1:0]      result_q,  result_d;

    logic                   in_ready;
    logic                   accept;
    logic                   pk_clr;
    logic [WORD_W-1:0]      pk_word;
    logic                   pk_done;

    assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign accept   = in_ready && bus.In_Valid;

    sad_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pk_clr),
        .byte_vld  (accept),
        .byte_dat  (bus.In_Data),
        .word_dat  (pk_word),
        .word_done (pk_done)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ma_en_d   = 1'b0;
        mb_en_d   = 1'b0;
        ma_addr_d = ma_addr_q;
        mb_addr_d = mb_addr_q;
        ma_di_d   = ma_di_q;
        mb_di_d   = mb_di_q;
        result_d  = result_q;
        pk_clr    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d = LOAD_A;
                    cnt_d   = '0;
                    pk_clr  = 1'b1;
                end
            end
            LOAD_A: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (pk_done) begin
                        ma_en_d   = 1'b1;
                        ma_addr_d = cnt_q[A_WIDTH-1:2];
                        ma_di_d   = pk_word;
                    end
                    if (cnt_q == LAST_BYTE) begin
                        state_d = LOAD_B;
                        cnt_d   = '0;
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (pk_done) begin
                        mb_en_d   = 1'b1;
                        mb_addr_d = cnt_q[A_WIDTH-1:2];
                        mb_di_d   = pk_word;
                    end
                    if (cnt_q == LAST_BYTE) begin
                        state_d = FLUSH;
                        cnt_d   = '0;
                    end
                end
            end
            // The last B word is being written during FLUSH.
            FLUSH:  state_d = GO;
            GO:     state_d = WAIT;
            WAIT: begin
                if (bus.Done_t) begin
                    result_d = bus.SAD_Out_t;
                    state_d  = RESULT;
                end
            end
            RESULT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ma_en_q   <= 1'b0;
            mb_en_q   <= 1'b0;
            ma_addr_q <= '0;
            mb_addr_q <= '0;
            ma_di_q   <= '0;
            mb_di_q   <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ma_en_q   <= ma_en_d;
            mb_en_q   <= mb_en_d;
            ma_addr_q <= ma_addr_d;
            mb_addr_q <= mb_addr_d;
            ma_di_q   <= ma_di_d;
            mb_di_q   <= mb_di_d;
            result_q  <= result_d;
        end
    end

    assign bus.In_Ready   = in_ready;
    assign bus.MA_enb     = ma_en_q;
    assign bus.MA_web     = ma_en_q;
    assign bus.MB_enb     = mb_en_q;
    assign bus.MB_web     = mb_en_q;
    assign bus.MA_Addr6   = ma_addr_q;
    assign bus.MB_Addr6   = mb_addr_q;
    assign bus.MA_di31    = ma_di_q;
    assign bus.MB_di31    = mb_di_q;
    assign bus.Go_t       = (state_q == GO);
    assign bus.Res_Valid  = (state_q == RESULT);
    assign bus.Sad_Result = result_q;
    assign bus.Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sad_loader.sv
// Randomised bench for sad_loader: memory images, write count, Go/Result timing, reset behaviour.
module tb_sad_loader;
    import sad_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sad_loader_if bus();

    sad_loader #(.BYTES_PER_BLOCK(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    logic [7:0]  a_bytes [256];
    logic [7:0]  b_bytes [256];
    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];

    int          wr_cnt     = 0;
    int          bad_cnt    = 0;
    int          go_cnt     = 0;
    int          go_cyc     = 0;
    int          res_cnt    = 0;
    int          res_cyc    = 0;
    int          last_b_cyc = 0;
    logic [31:0] res_val    = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory and handshake observer: acts as both SAD memories and logs core pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.MA_enb) begin
                mem_a[bus.MA_Addr6] = bus.MA_di31;
                wr_cnt++;
            end
            if (bus.MB_enb) begin
                mem_b[bus.MB_Addr6] = bus.MB_di31;
                wr_cnt++;
            end
            if (bus.MA_enb && bus.MB_enb) bad_cnt++;
            if ((bus.MA_enb != bus.MA_web) || (bus.MB_enb != bus.MB_web)) bad_cnt++;
            if (bus.Go_t) begin
                go_cnt++;
                go_cyc = cyc;
            end
            if (bus.Res_Valid) begin
                res_cnt++;
                res_cyc = cyc;
                res_val = bus.Sad_Result;
            end
        end
    end

    task automatic clear_mem();
        for (int w = 0; w < 64; w++) begin
            mem_a[w] = 32'hDEAD_BEEF;
            mem_b[w] = 32'hDEAD_BEEF;
        end
    endtask

    task automatic randomize_bytes();
        for (int i = 0; i < 256; i++) begin
            a_bytes[i] = 8'($urandom_range(255));
            b_bytes[i] = 8'($urandom_range(255));
        end
    endtask

    function automatic logic [31:0] exp_word(input bit is_b, input int w);
        if (is_b) return {b_bytes[4*w+3], b_bytes[4*w+2], b_bytes[4*w+1], b_bytes[4*w]};
        return {a_bytes[4*w+3], a_bytes[4*w+2], a_bytes[4*w+1], a_bytes[4*w]};
    endfunction

    task automatic check_image(input string tag);
        int bad_a = 0;
        int bad_b = 0;
        for (int w = 0; w < 64; w++) begin
            if (mem_a[w] !== exp_word(1'b0, w)) bad_a++;
            if (mem_b[w] !== exp_word(1'b1, w)) bad_b++;
        end
        chk({tag, "_img_a_bad_words"}, bad_a, 0);
        chk({tag, "_img_b_bad_words"}, bad_b, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {24'd0, bus.In_Ready, bus.MA_enb, bus.MA_web, bus.MB_enb,
                            bus.MB_web, bus.Go_t, bus.Res_Valid, bus.Busy}, 32'd0);
        chk({tag, "_addr"}, {20'd0, bus.MA_Addr6, bus.MB_Addr6}, 32'd0);
        chk({tag, "_di_a"}, bus.MA_di31, 32'd0);
        chk({tag, "_di_b"}, bus.MB_di31, 32'd0);
        chk({tag, "_result"}, bus.Sad_Result, 32'd0);
    endtask

    // Called at a negedge with the loader idle; pulses Start then feeds n_bytes.
    task automatic stream(input int n_bytes, input int bubble_pct, input int start_at);
        int idx    = 0;
        int guard  = 0;
        bit pulsed = 1'b0;
        bus.Start = 1'b1;
        while (idx < n_bytes && guard < 4000) begin
            @(negedge clk);
            guard++;
            bus.Start = 1'b0;
            if (!pulsed && start_at >= 0 && idx == start_at) begin
                bus.Start = 1'b1;
                pulsed    = 1'b1;
            end
            if ($urandom_range(99) < bubble_pct) begin
                bus.In_Valid = 1'b0;
                bus.In_Data  = 8'($urandom_range(255));
            end else begin
                bus.In_Valid = 1'b1;
                bus.In_Data  = (idx < 256) ? a_bytes[idx] : b_bytes[idx-256];
                if (bus.In_Ready) begin
                    if (idx == 511) last_b_cyc = cyc;
                    idx++;
                end
            end
        end
        @(negedge clk);
        bus.In_Valid = 1'b0;
        bus.Start    = 1'b0;
        chk("stream_bytes_taken", idx, n_bytes);
    endtask

    task automatic wait_go(input int prev);
        int g = 0;
        while (go_cnt == prev && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("go_seen", go_cnt - prev, 1);
    endtask

    task automatic wait_res(input int prev);
        int g = 0;
        while (res_cnt == prev && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("res_seen", res_cnt - prev, 1);
    endtask

    // core_delay = 0 means Done_t is already held high for the whole run.
    task automatic do_run(input string tag, input int bubble, input int start_at,
                          input int core_delay, input logic [31:0] sad);
        int w0 = wr_cnt;
        int g0 = go_cnt;
        int r0 = res_cnt;
        int s0 = bad_cnt;
        clear_mem();
        if (core_delay == 0) begin
            bus.Done_t    = 1'b1;
            bus.SAD_Out_t = sad;
        end
        stream(512, bubble, start_at);
        wait_go(g0);
        chk({tag, "_go_latency"}, go_cyc - last_b_cyc, 2);
        if (core_delay > 0) begin
            repeat (100) @(negedge clk);
            bus.Start = 1'b1;
            @(negedge clk);
            bus.Start = 1'b0;
            chk({tag, "_start_in_wait"}, {30'd0, bus.Busy, bus.In_Ready}, 32'd2);
            repeat (core_delay - 101) @(negedge clk);
            bus.SAD_Out_t = sad;
            bus.Done_t    = 1'b1;
        end
        wait_res(r0);
        if (core_delay > 0) bus.Done_t = 1'b0;
        else chk({tag, "_res_after_go"}, res_cyc - go_cyc, 2);
        @(negedge clk);
        chk({tag, "_idle"}, {29'd0, bus.Busy, bus.Res_Valid, bus.In_Ready}, 32'd0);
        chk({tag, "_result"}, res_val, sad);
        chk({tag, "_result_hold"}, bus.Sad_Result, sad);
        repeat (5) @(negedge clk);
        chk({tag, "_res_pulses"}, res_cnt - r0, 1);
        chk({tag, "_go_pulses"}, go_cnt - g0, 1);
        chk({tag, "_writes"}, wr_cnt - w0, 128);
        chk({tag, "_strobe_errs"}, bad_cnt - s0, 0);
        check_image(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        bus.Start     = 1'b0;
        bus.In_Valid  = 1'b0;
        bus.In_Data   = '0;
        bus.Done_t    = 1'b0;
        bus.SAD_Out_t = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Ramp data, no bubbles, slow core, stray Start in WAIT.
        for (int i = 0; i < 256; i++) begin
            a_bytes[i] = 8'(i);
            b_bytes[i] = 8'(255 - i);
        end
        do_run("ramp", 0, -1, 700, 32'h0000_FF00);
        chk("ramp_a_w0", mem_a[0], 32'h0302_0100);
        chk("ramp_a_w63", mem_a[63], 32'hFFFE_FDFC);
        chk("ramp_b_w0", mem_b[0], 32'hFCFD_FEFF);

        // Random data with bubbles, stray Start in LOAD_B, Done_t held across two runs.
        randomize_bytes();
        do_run("rand1", 30, 300, 0, $urandom);
        randomize_bytes();
        do_run("rand2", 30, -1, 0, $urandom);
        bus.Done_t = 1'b0;

        // Reset mid-way through memory A, then a clean reload.
        randomize_bytes();
        clear_mem();
        stream(130, 0, -1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        randomize_bytes();
        do_run("reload", 20, -1, 0, $urandom);
        chk("reload_a_w32", mem_a[32], exp_word(1'b0, 32));
        bus.Done_t = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
